// File: rtl/colour_pipeline_if.sv
// Pixel-path bus for colour_pipeline: byte/load strobes, palette write port
// and colour output. master = sequencer/testbench side, slave = pipeline.
interface colour_pipeline_if #(
    parameter int COLOUR_W = 5
);
    logic                PIX_CE;
    logic                LOAD;
    logic [7:0]          DATA;
    logic                DISP_EN;
    logic                BLANK;
    logic [1:0]          MODE;
    logic                PEN_WE;
    logic [4:0]          PEN_ADDR;
    logic [COLOUR_W-1:0] PEN_DATA;
    logic [COLOUR_W-1:0] COLOUR;
    logic [3:0]          PEN_IDX;
    logic                UNDERRUN;

    modport master (
        output PIX_CE, LOAD, DATA, DISP_EN, BLANK, MODE,
        output PEN_WE, PEN_ADDR, PEN_DATA,
        input  COLOUR, PEN_IDX, UNDERRUN
    );

    modport slave (
        input  PIX_CE, LOAD, DATA, DISP_EN, BLANK, MODE,
        input  PEN_WE, PEN_ADDR, PEN_DATA,
        output COLOUR, PEN_IDX, UNDERRUN
    );
endinterface

// File: rtl/colour_pipeline.sv
// colour_pipeline: latches video bytes, serialises them per screen mode,
// looks up ink/border palette and registers colour through OUT_STAGES.
// Ports: CLK_n, RESET (async, active high), bus (colour_pipeline_if.slave):
//   PIX_CE/LOAD/DATA/DISP_EN/MODE/BLANK in, PEN_WE/PEN_ADDR/PEN_DATA in,
//   COLOUR/PEN_IDX/UNDERRUN out.
// Option: define COLOUR_PIPELINE_MODE3_EN to decode MODE=3 as 4-colour
//   mode 3; otherwise MODE=3 decodes exactly as mode 0.
// The interface COLOUR_W must match this module's COLOUR_W.
module colour_pipeline #(
    parameter int                  COLOUR_W     = 5,
    parameter int                  OUT_STAGES   = 1,
    parameter logic [COLOUR_W-1:0] RESET_COLOUR = '0
) (
    input logic              CLK_n,
    input logic              RESET,
    colour_pipeline_if.slave bus
);
    localparam int         NPEN     = 17;
    localparam logic [4:0] BORDER   = 5'd16;
    localparam logic [3:0] SLOT_END = 4'd8;

    logic [7:0]          byte_q, byte_d;
    logic [1:0]          mode_q, mode_d;
    logic                disp_q, disp_d;
    logic [3:0]          slot_q, slot_d;
    logic                under_q, under_d;
    logic [3:0]          pen_q, pen_d;
    logic [COLOUR_W-1:0] pal_q [NPEN];
    logic [COLOUR_W-1:0] pal_d [NPEN];
    logic [COLOUR_W-1:0] stg_q [OUT_STAGES];
    logic [COLOUR_W-1:0] stg_d [OUT_STAGES];

    logic [2:0]          s;
    logic [3:0]          mode0_pen;
    logic [3:0]          pix_pen;
    logic                use_border;
    logic [COLOUR_W-1:0] src_colour;
    logic [3:0]          src_pen;

    // Bit indices 7-p, 5-p, 3-p, 1-p are formed by inverting the
    // pixel number into the low index bits.
    always_comb begin
        s         = slot_q[2:0];
        mode0_pen = {byte_q[{2'b00, ~s[2]}], byte_q[{2'b10, ~s[2]}],
                     byte_q[{2'b01, ~s[2]}], byte_q[{2'b11, ~s[2]}]};
        pix_pen   = mode0_pen;
        case (mode_q)
            2'd1: pix_pen = {2'b00, byte_q[{1'b0, ~s[2:1]}],
                             byte_q[{1'b1, ~s[2:1]}]};
            2'd2: pix_pen = {3'b000, byte_q[~s]};
`ifdef COLOUR_PIPELINE_MODE3_EN
            2'd3: pix_pen = {2'b00, byte_q[{2'b10, ~s[2]}],
                             byte_q[{2'b11, ~s[2]}]};
`endif
            default: pix_pen = mode0_pen;
        endcase
    end

    // Slot 8 means the byte ran out before the next LOAD.
    always_comb begin
        use_border = !disp_q || (slot_q == SLOT_END);
        src_colour = pal_q[{1'b0, pix_pen}];
        src_pen    = pix_pen;
        priority case (1'b1)
            bus.BLANK: begin
                src_colour = '0;
                src_pen    = '0;
            end
            use_border: begin
                src_colour = pal_q[BORDER];
                src_pen    = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_d  = byte_q;
        mode_d  = mode_q;
        disp_d  = disp_q;
        slot_d  = slot_q;
        under_d = under_q;
        if (bus.PIX_CE) begin
            if (bus.LOAD) begin
                byte_d = bus.DATA;
                mode_d = bus.MODE;
                disp_d = bus.DISP_EN;
                slot_d = '0;
            end else if (slot_q != SLOT_END) begin
                slot_d = slot_q + 4'd1;
                if (slot_q == SLOT_END - 4'd1) begin
                    under_d = 1'b1;
                end
            end
        end
    end

    // Lookups read pal_q, so a same-edge write is seen one edge later.
    always_comb begin
        for (int i = 0; i < NPEN; i++) begin
            pal_d[i] = pal_q[i];
            if (bus.PEN_WE && (bus.PEN_ADDR == 5'(i))) begin
                pal_d[i] = bus.PEN_DATA;
            end
        end
    end

    always_comb begin
        pen_d = pen_q;
        for (int k = 0; k < OUT_STAGES; k++) begin
            stg_d[k] = stg_q[k];
        end
        if (bus.PIX_CE) begin
            stg_d[0] = src_colour;
            pen_d    = src_pen;
            for (int k = 1; k < OUT_STAGES; k++) begin
                stg_d[k] = stg_q[k-1];
            end
        end
    end

    always_ff @(posedge CLK_n or posedge RESET) begin
        if (RESET) begin
            byte_q  <= '0;
            mode_q  <= '0;
            disp_q  <= 1'b0;
            slot_q  <= '0;
            under_q <= 1'b0;
            pen_q   <= '0;
            for (int i = 0; i < NPEN; i++) begin
                pal_q[i] <= RESET_COLOUR;
            end
            for (int k = 0; k < OUT_STAGES; k++) begin
                stg_q[k] <= RESET_COLOUR;
            end
        end else begin
            byte_q  <= byte_d;
            mode_q  <= mode_d;
            disp_q  <= disp_d;
            slot_q  <= slot_d;
            under_q <= under_d;
            pen_q   <= pen_d;
            for (int i = 0; i < NPEN; i++) begin
                pal_q[i] <= pal_d[i];
            end
            for (int k = 0; k < OUT_STAGES; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    assign bus.COLOUR   = stg_q[OUT_STAGES-1];
    assign bus.PEN_IDX  = pen_q;
    assign bus.UNDERRUN = under_q;
endmodule

// File: tb/tb_colour_pipeline.sv
// Testbench for colour_pipeline: directed test-plan steps then random
// traffic, checked against a behavioural model of slots and palette.
module tb_colour_pipeline;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    colour_pipeline_if #(.COLOUR_W(CW)) bus();

    colour_pipeline #(
        .COLOUR_W(CW),
        .OUT_STAGES(1),
        .RESET_COLOUR('0)
    ) dut (
        .CLK_n(clk),
        .RESET(rst),
        .bus(bus.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]    m_byte;
    logic [1:0]    m_mode;
    logic          m_disp;
    int            m_slot;
    logic          m_under;
    logic [CW-1:0] m_pal [17];
    logic [CW-1:0] exp_c;
    logic [3:0]    exp_p;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_byte  = 8'h00;
        m_mode  = 2'd0;
        m_disp  = 1'b0;
        m_slot  = 0;
        m_under = 1'b0;
        exp_c   = '0;
        exp_p   = 4'd0;
        for (int i = 0; i < 17; i++) m_pal[i] = '0;
    endtask

    function automatic logic bt(logic [7:0] b, int i);
        logic [2:0] j;
        j = i[2:0];
        return b[j];
    endfunction

    // Pen of slot s straight from the mode tables.
    function automatic logic [3:0] ref_pen(logic [7:0] b, logic [1:0] m,
                                           int s);
        int p;
        int mm;
        logic [3:0] r;
        mm = int'(m);
`ifndef COLOUR_PIPELINE_MODE3_EN
        if (mm == 3) mm = 0;
`endif
        r = 4'd0;
        case (mm)
            0: begin
                p = s / 4;
                r = {bt(b, 1-p), bt(b, 5-p), bt(b, 3-p), bt(b, 7-p)};
            end
            1: begin
                p = s / 2;
                r = {2'b00, bt(b, 3-p), bt(b, 7-p)};
            end
            2: r = {3'b000, bt(b, 7-s)};
            default: begin
                p = s / 4;
                r = {2'b00, bt(b, 5-p), bt(b, 7-p)};
            end
        endcase
        return r;
    endfunction

    task automatic step(input logic pce, input logic ld,
                        input logic [7:0] d, input logic [1:0] m,
                        input logic de, input logic bl,
                        input logic we, input logic [4:0] wa,
                        input logic [CW-1:0] wd);
        logic [3:0] pen;
        @(negedge clk);
        bus.PIX_CE   = pce;
        bus.LOAD     = ld;
        bus.DATA     = d;
        bus.MODE     = m;
        bus.DISP_EN  = de;
        bus.BLANK    = bl;
        bus.PEN_WE   = we;
        bus.PEN_ADDR = wa;
        bus.PEN_DATA = wd;
        if (pce) begin
            pen = (m_slot < 8) ? ref_pen(m_byte, m_mode, m_slot) : 4'd0;
            if (bl) begin
                exp_c = '0;
                exp_p = 4'd0;
            end else if (!m_disp || m_slot == 8) begin
                exp_c = m_pal[16];
                exp_p = 4'd0;
            end else begin
                exp_c = m_pal[pen];
                exp_p = pen;
            end
            if (ld) begin
                m_byte = d;
                m_mode = m;
                m_disp = de;
                m_slot = 0;
            end else if (m_slot < 8) begin
                m_slot++;
                if (m_slot == 8) m_under = 1'b1;
            end
        end
        if (we && wa <= 5'd16) m_pal[wa] = wd;
        @(posedge clk);
        #1;
        bus.PIX_CE = 1'b0;
        bus.LOAD   = 1'b0;
        bus.PEN_WE = 1'b0;
        chk("colour", 32'(bus.COLOUR), 32'(exp_c));
        chk("pen_idx", 32'(bus.PEN_IDX), 32'(exp_p));
        chk("underrun", 32'(bus.UNDERRUN), 32'(m_under));
    endtask

    task automatic wr(input logic [4:0] a, input logic [CW-1:0] v);
        step(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, a, v);
    endtask

    task automatic tick(input logic ld, input logic [7:0] d,
                        input logic [1:0] m, input logic de);
        step(1'b1, ld, d, m, de, 1'b0, 1'b0, 5'd0, '0);
    endtask

    // Load d, then play its 8 slots; want holds slot0..7 pens MSB first.
    task automatic byte_seq(input logic [7:0] d, input logic [1:0] m,
                            input logic [1:0] m_later,
                            input logic [31:0] want);
        tick(1'b1, d, m, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick(k == 7, d, (k == 7) ? m : m_later, 1'b1);
            chk("plan_pen", 32'(bus.PEN_IDX), 32'(want[31-4*k -: 4]));
        end
    endtask

    task automatic load_palette();
        wr(5'd15, 5'h1A);
        wr(5'd0,  5'h04);
        wr(5'd16, 5'h14);
        wr(5'd5,  5'h07);
        wr(5'd3,  5'h0B);
        wr(5'd1,  5'h11);
        wr(5'd20, 5'h1F);
    endtask

    initial begin
        rst          = 1'b1;
        bus.PIX_CE   = 1'b0;
        bus.LOAD     = 1'b0;
        bus.DATA     = 8'h00;
        bus.MODE     = 2'd0;
        bus.DISP_EN  = 1'b0;
        bus.BLANK    = 1'b0;
        bus.PEN_WE   = 1'b0;
        bus.PEN_ADDR = 5'd0;
        bus.PEN_DATA = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_colour", 32'(bus.COLOUR), 32'h0);
        chk("rst_pen", 32'(bus.PEN_IDX), 32'h0);
        chk("rst_under", 32'(bus.UNDERRUN), 32'h0);
        rst = 1'b0;

        load_palette();
        tick(1'b0, 8'h00, 2'd0, 1'b1);
        chk("border_pre_load", 32'(bus.COLOUR), 32'h14);
        tick(1'b0, 8'h00, 2'd0, 1'b1);

        byte_seq(8'hAA, 2'd0, 2'd0, 32'hFFFF_0000);
        byte_seq(8'hAA, 2'd1, 2'd1, 32'h3300_3300);
        byte_seq(8'h81, 2'd2, 2'd2, 32'h1000_0001);
        byte_seq(8'h81, 2'd2, 2'd0, 32'h1000_0001);
`ifdef COLOUR_PIPELINE_MODE3_EN
        byte_seq(8'hAA, 2'd3, 2'd3, 32'h3333_0000);
`else
        byte_seq(8'hAA, 2'd3, 2'd3, 32'hFFFF_0000);
`endif

        tick(1'b1, 8'hAA, 2'd0, 1'b1);
        tick(1'b0, 8'hAA, 2'd0, 1'b1);
        chk("ink15", 32'(bus.COLOUR), 32'h1A);

        tick(1'b1, 8'h55, 2'd0, 1'b0);
        tick(1'b0, 8'h55, 2'd0, 1'b0);
        chk("border_disp0", 32'(bus.COLOUR), 32'h14);

        tick(1'b1, 8'hA0, 2'd0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1, 5'd5, 5'h19);
        chk("pen5_old", 32'(bus.COLOUR), 32'h07);
        tick(1'b0, 8'h00, 2'd0, 1'b1);
        chk("pen5_new", 32'(bus.COLOUR), 32'h19);

        step(1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0, 5'd0, '0);
        chk("blank", 32'(bus.COLOUR), 32'h0);

        tick(1'b1, 8'hFF, 2'd2, 1'b1);
        for (int k = 0; k < 9; k++) tick(1'b0, 8'h00, 2'd2, 1'b1);
        chk("slot8_border", 32'(bus.COLOUR), 32'h14);
        chk("underrun_set", 32'(bus.UNDERRUN), 32'h1);
        tick(1'b1, 8'hAA, 2'd0, 1'b1);
        tick(1'b0, 8'hAA, 2'd0, 1'b1);
        chk("underrun_sticky", 32'(bus.UNDERRUN), 32'h1);

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_colour", 32'(bus.COLOUR), 32'h0);
        chk("async_pen", 32'(bus.PEN_IDX), 32'h0);
        chk("async_under", 32'(bus.UNDERRUN), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        load_palette();

        for (int i = 0; i < 400; i++) begin
            logic       pce;
            logic       ld;
            logic       we;
            pce = ($urandom % 4) != 0;
            if (m_slot >= 7) ld = ($urandom % 4) != 0;
            else             ld = ($urandom % 12) == 0;
            we = ($urandom % 5) == 0;
            step(pce, ld && pce, 8'($urandom), 2'($urandom),
                 ($urandom % 6) != 0, ($urandom % 10) == 0,
                 we, 5'($urandom), CW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
